uart_cmd_rx: RTL and testbench
==============================

UART_CMD_RX -- requirements
Module: uart_cmd_rx

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 2604, meaning clocks per bit (50 MHz / 19200 baud); legal values are even and >= 8.
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port RX, input, 1 bit: asynchronous serial line, idle high.
REQ-005 SHALL have port clr_rdy, input, 1 bit: consumer acknowledge; clears rdy.
REQ-006 SHALL have port rx_data, output, 8 bits: last correctly framed byte.
REQ-007 SHALL have port rdy, output, 1 bit: rx_data holds an unread byte.
REQ-008 SHALL have port frm_err, output, 1 bit: sticky; last frame had stop bit = 0.
REQ-009 SHALL have port ovr_err, output, 1 bit: sticky; a byte completed while rdy was still set.
REQ-010 SHALL have port go, output, 1 bit: one-cycle pulse on receipt of 8'h67.
REQ-011 SHALL have port stop, output, 1 bit: one-cycle pulse on receipt of 8'h73.

Function
REQ-012 SHALL pass RX through two flops, rising-edge clocked and reset to 1, before any use; only the synchronized value is sampled.
REQ-013 SHALL implement the states IDLE, START, DATA and STOP.
REQ-014 In IDLE, when the synchronized RX is 0, the block SHALL enter START and load the baud counter with BAUD_DIV/2.
REQ-015 When the counter expires in START, the block SHALL sample RX: if 0, enter DATA and load BAUD_DIV; if 1, treat it as a glitch and return to IDLE with no flag change.
REQ-016 In DATA, the block SHALL sample 8 bits, LSB first, each at counter expiry, reloading BAUD_DIV after each; after bit 7 it SHALL enter STOP.
REQ-017 At STOP expiry with RX = 1, the block SHALL load rx_data, set rdy, and return to IDLE.
REQ-018 At STOP expiry with RX = 0, the block SHALL set frm_err, leave rx_data and rdy unchanged, and wait in STOP until RX = 1 before entering IDLE.
REQ-019 rdy SHALL assert exactly one cycle after the stop-bit sample edge.
REQ-020 Start-edge-to-rdy latency SHALL be 2 sync cycles + 9.5*BAUD_DIV +/- 1 cycle.
REQ-021 rdy SHALL clear on clr_rdy or on a start-bit detection in IDLE.
REQ-022 If clr_rdy and byte completion occur in the same cycle, completion SHALL win: rdy=1 with the new data.
REQ-023 If rdy=1 at byte completion, the block SHALL overwrite rx_data and set ovr_err. Note: this applies only while clr_rdy holds at the completion edge, because start detection clears rdy under REQ-021.
REQ-024 frm_err and ovr_err SHALL clear only when clr_rdy is asserted in a cycle with no simultaneous completion.
REQ-025 go or stop SHALL pulse in the same cycle rdy rises, and only for correctly framed bytes.
REQ-026 go and stop SHALL never be asserted simultaneously.
REQ-027 The baud counter SHALL be log2(BAUD_DIV)+1 bits, count down, and expire at 0.

Reset
REQ-028 While rst is high, the block SHALL be in IDLE with counter=0, bit index=0, sync flops=1, and all outputs 0 (rx_data=8'h00).
REQ-029 rst asserted mid-frame SHALL abort the frame immediately.
REQ-030 After rst deasserts, the next falling edge SHALL be treated as a new start bit.

Configuration
REQ-031 The macro CMD_DECODE_EN SHALL control command decode.
REQ-032 With CMD_DECODE_EN defined, go and stop SHALL behave per REQ-025 and REQ-026.
REQ-033 Without CMD_DECODE_EN, go and stop SHALL be tied to 0, no compare logic SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-034 BAUD_DIV=16, send 8'h67 with a valid stop bit -> rdy=1 and rx_data=8'h67 at 2+152+/-1 cycles after the start edge; go pulses for 1 cycle; frm_err=0.
REQ-035 Send 8'h73, then 8'hA5 without clr_rdy -> the stop pulse is seen; start of the second frame clears rdy; final rdy=1, rx_data=8'hA5, ovr_err=0. Then assert clr_rdy on the exact cycle a third byte 8'h3C completes -> rdy=1, rx_data=8'h3C, ovr_err=1.
REQ-036 Send 8'h55 with stop bit=0, held low 3 extra bits -> frm_err=1, rdy unchanged, no return to IDLE until RX rises; then send 8'h01 -> rdy=1, rx_data=8'h01.
REQ-037 A 4-cycle low glitch on idle RX -> return to IDLE; rdy, frm_err and rx_data unchanged.
REQ-038 Assert rst at data bit 4 of 8'hFF -> all outputs 0 immediately; a subsequent 8'h67 is received correctly.
REQ-039 Build without CMD_DECODE_EN and repeat REQ-034 -> identical rdy/rx_data; go stays 0.

Source files
------------

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 UART receiver with a ready/acknowledge handshake,
// sticky framing and overrun flags, and an optional command decoder that
// pulses go on 8'h67 ('g') and stop on 8'h73 ('s').
// Build option: define CMD_DECODE_EN to include the command decoder;
// without it go and stop are constant 0 and no compare logic exists.
module uart_cmd_rx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       ovr_err,
  output logic       go,
  output logic       stop
);

  // Smallest width that still holds BAUD_DIV itself (floor(log2)+1).
  localparam int CNT_W = $clog2(BAUD_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_rx_meta;
  logic             r_rx_sync;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_rx_data;
  logic             r_rdy;
  logic             r_frm_err;
  logic             r_ovr_err;

  logic w_rx;
  logic w_expire;
  logic w_load_half;
  logic w_load_full;
  logic w_sample;
  logic w_start_ok;
  logic w_done;
  logic w_frame_bad;

  assign w_rx = r_rx_sync;
  // A count "expires" on the decrement that takes it to zero, so a load of
  // N yields an expiry exactly N clocks later.
  assign w_expire = (r_cnt == CNT_ONE);

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= RX;
      r_rx_sync <= r_rx_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (!w_rx) w_state_next = START;
      START:   if (w_expire) w_state_next = w_rx ? IDLE : DATA;
      DATA:    if (w_expire && (r_bit_idx == 3'd7)) w_state_next = STOP;
      // After a bad stop bit the counter sits at 0; hold here until the
      // line returns high so a stuck-low line is not taken as a new start.
      STOP:    if ((w_expire || (r_cnt == '0)) && w_rx) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // FSM output decode: counter loads and datapath strobes.
  always_comb begin
    w_load_half = 1'b0;
    w_load_full = 1'b0;
    w_sample    = 1'b0;
    w_start_ok  = 1'b0;
    w_done      = 1'b0;
    w_frame_bad = 1'b0;
    case (r_state)
      IDLE: w_load_half = !w_rx;
      START: begin
        if (w_expire && !w_rx) begin
          w_load_full = 1'b1;
          w_start_ok  = 1'b1;
        end
      end
      DATA: begin
        if (w_expire) begin
          w_sample    = 1'b1;
          w_load_full = 1'b1;
        end
      end
      STOP: begin
        if (w_expire) begin
          w_done      = w_rx;
          w_frame_bad = !w_rx;
        end
      end
      default: ;
    endcase
  end

  // Baud counter: half a bit to reach the start-bit centre, then whole bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_load_half) begin
      r_cnt <= CNT_HALF;
    end else if (w_load_full) begin
      r_cnt <= CNT_FULL;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_ONE;
    end
  end

  // Data bit index, only meaningful while in DATA.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_idx <= 3'd0;
    end else if (r_state != DATA) begin
      r_bit_idx <= 3'd0;
    end else if (w_sample) begin
      r_bit_idx <= r_bit_idx + 3'd1;
    end
  end

  // LSB-first shift register: each new bit enters at the top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= 8'h00;
    end else if (w_sample) begin
      r_shift <= {w_rx, r_shift[7:1]};
    end
  end

  // Handshake and sticky error flags. Completion beats a same-cycle
  // acknowledge; an acknowledge landing on completion counts as overrun.
  // rdy is dropped on a confirmed start bit, so a line glitch leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_data <= 8'h00;
      r_rdy     <= 1'b0;
      r_ovr_err <= 1'b0;
      r_frm_err <= 1'b0;
    end else begin
      if (w_done) begin
        r_rx_data <= r_shift;
        r_rdy     <= 1'b1;
        if (r_rdy || clr_rdy) r_ovr_err <= 1'b1;
      end else begin
        if (clr_rdy || w_start_ok) r_rdy <= 1'b0;
        if (clr_rdy) r_ovr_err <= 1'b0;
      end
      if (w_frame_bad) begin
        r_frm_err <= 1'b1;
      end else if (clr_rdy && !w_done) begin
        r_frm_err <= 1'b0;
      end
    end
  end

  assign rx_data = r_rx_data;
  assign rdy     = r_rdy;
  assign frm_err = r_frm_err;
  assign ovr_err = r_ovr_err;

`ifdef CMD_DECODE_EN
  logic r_go;
  logic r_stop;

  // Command pulses share the completion edge with rdy, so they are exclusive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_go   <= 1'b0;
      r_stop <= 1'b0;
    end else begin
      r_go   <= w_done && (r_shift == 8'h67);
      r_stop <= w_done && (r_shift == 8'h73);
    end
  end

  assign go   = r_go;
  assign stop = r_stop;
`else
  assign go   = 1'b0;
  assign stop = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: table-driven directed frames, hand sequences for glitch,
// stuck-low stop and mid-frame reset, then random frames against a
// frame-level reference model. Inputs are driven and outputs sampled on
// the falling clock edge.
module tb_uart_cmd_rx;

  localparam int BD = 16;
  localparam int FRAME_STEPS = 10 * BD;
  // Clock edges from driving the start bit to the stop-bit sample edge:
  // two synchronizer stages, one detect cycle, then 9.5 bit times.
  localparam int DONE_EDGE = 3 + BD / 2 + 9 * BD;

`ifdef CMD_DECODE_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       RX = 1'b1;
  logic       clr_rdy = 1'b0;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       ovr_err;
  logic       go;
  logic       stop;

  always #5 clk = ~clk;

  uart_cmd_rx #(.BAUD_DIV(BD)) dut (
    .clk     (clk),
    .rst     (rst),
    .RX      (RX),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy),
    .frm_err (frm_err),
    .ovr_err (ovr_err),
    .go      (go),
    .stop    (stop)
  );

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    int         extra;
    logic       clr_before;
    logic       clr_done;
    logic [7:0] exp_data;
    logic       exp_rdy;
    logic       exp_frm;
    logic       exp_ovr;
    int         exp_go;
    int         exp_stop;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   go_cnt = 0;
  int   stop_cnt = 0;
  int   pulse_err = 0;
  logic mon_prev_rdy = 1'b0;

  logic [7:0] m_data;
  logic       m_rdy;
  logic       m_frm;
  logic       m_ovr;

  vec_t tbl [7];

  // Pulse monitor: go/stop only on the rdy rising cycle, never together,
  // and only for the matching command byte.
  always @(negedge clk) begin
    if ((go || stop) && !(rdy && !mon_prev_rdy)) pulse_err++;
    if (go && stop) pulse_err++;
    if (go && (rx_data !== 8'h67)) pulse_err++;
    if (stop && (rx_data !== 8'h73)) pulse_err++;
    if (go) go_cnt++;
    if (stop) stop_cnt++;
    mon_prev_rdy = rdy;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Line level at a given step of a frame: start, 8 data LSB first, stop,
  // optional extra low bit times, then idle high.
  function automatic logic level_at(input logic [7:0] b, input logic sbit,
                                    input int extra, input int step);
    int bit_no;
    bit_no = step / BD;
    if (bit_no == 0) return 1'b0;
    if (bit_no <= 8) return b[bit_no-1];
    if (bit_no == 9) return sbit;
    if (bit_no < 10 + extra) return 1'b0;
    return 1'b1;
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic sbit, input int extra,
                            input int clr_step, output int lat, output int go_n,
                            output int stop_n);
    int   g0;
    int   s0;
    int   steps;
    logic prev;
    g0    = go_cnt;
    s0    = stop_cnt;
    prev  = rdy;
    steps = FRAME_STEPS + extra * BD + 8;
    lat   = -1;
    for (int j = 0; j < steps; j++) begin
      RX      = level_at(b, sbit, extra, j);
      clr_rdy = (j == clr_step);
      @(negedge clk);
      if (rdy && !prev && (lat < 0)) lat = j + 1;
      prev = rdy;
    end
    clr_rdy = 1'b0;
    go_n    = go_cnt - g0;
    stop_n  = stop_cnt - s0;
  endtask

  task automatic run_row(input vec_t v, input string tag);
    int lat;
    int gn;
    int sn;
    if (v.clr_before) begin
      clr_rdy = 1'b1;
      @(negedge clk);
      clr_rdy = 1'b0;
      @(negedge clk);
    end
    send_frame(v.data, v.stop_ok, v.extra, v.clr_done ? DONE_EDGE - 1 : -1, lat, gn, sn);
    $display("%s: byte=%02h stop_bit=%0b clr_done=%0b -> rx_data=%02h rdy=%0b frm_err=%0b ovr_err=%0b go=%0d stop=%0d latency=%0d",
             tag, v.data, v.stop_ok, v.clr_done, rx_data, rdy, frm_err, ovr_err, gn, sn, lat);
    chk({tag, ".rx_data"}, 32'(rx_data), 32'(v.exp_data));
    chk({tag, ".rdy"}, 32'(rdy), 32'(v.exp_rdy));
    chk({tag, ".frm_err"}, 32'(frm_err), 32'(v.exp_frm));
    chk({tag, ".ovr_err"}, 32'(ovr_err), 32'(v.exp_ovr));
    chk({tag, ".go_pulses"}, 32'(gn), 32'(v.exp_go));
    chk({tag, ".stop_pulses"}, 32'(sn), 32'(v.exp_stop));
    if (v.stop_ok) begin
      checks++;
      if ((lat < DONE_EDGE - 2) || (lat > DONE_EDGE)) begin
        errors++;
        $display("FAIL %s.latency: got %0d, expected %0d..%0d", tag, lat, DONE_EDGE - 2, DONE_EDGE);
      end
    end else begin
      chk({tag, ".no_rdy_rise"}, 32'(lat), 32'(-1));
    end
  endtask

  // Frame-level reference: a confirmed start drops rdy, a good stop delivers
  // the byte, a bad stop only raises frm_err, an ack on completion is overrun.
  function automatic vec_t model_predict(input vec_t v);
    vec_t r;
    r = v;
    if (v.clr_before) begin
      m_rdy = 1'b0;
      m_frm = 1'b0;
      m_ovr = 1'b0;
    end
    m_rdy = 1'b0;
    if (v.stop_ok) begin
      m_data = v.data;
      m_rdy  = 1'b1;
      if (v.clr_done) m_ovr = 1'b1;
    end else begin
      m_frm = 1'b1;
    end
    r.exp_data = m_data;
    r.exp_rdy  = m_rdy;
    r.exp_frm  = m_frm;
    r.exp_ovr  = m_ovr;
    r.exp_go   = (DEC_EN && v.stop_ok && (v.data == 8'h67)) ? 1 : 0;
    r.exp_stop = (DEC_EN && v.stop_ok && (v.data == 8'h73)) ? 1 : 0;
    return r;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, ".rx_data"}, 32'(rx_data), 32'h0);
    chk({tag, ".rdy"}, 32'(rdy), 32'h0);
    chk({tag, ".frm_err"}, 32'(frm_err), 32'h0);
    chk({tag, ".ovr_err"}, 32'(ovr_err), 32'h0);
    chk({tag, ".go"}, 32'(go), 32'h0);
    chk({tag, ".stop"}, 32'(stop), 32'h0);
  endtask

  initial begin
    vec_t v;
    int   lat;
    int   gn;
    int   sn;
    int   pick;

    //            data   ok   ext clrb clrd  exp_data rdy  frm  ovr  go      stop
    tbl[0] = '{8'h67, 1'b1, 0, 1'b0, 1'b0, 8'h67, 1'b1, 1'b0, 1'b0, int'(DEC_EN), 0};
    tbl[1] = '{8'h73, 1'b1, 0, 1'b0, 1'b0, 8'h73, 1'b1, 1'b0, 1'b0, 0, int'(DEC_EN)};
    tbl[2] = '{8'hA5, 1'b1, 0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 0, 0};
    tbl[3] = '{8'h3C, 1'b1, 0, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 0, 0};
    tbl[4] = '{8'h55, 1'b0, 3, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 0, 0};
    tbl[5] = '{8'h01, 1'b1, 0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 0, 0};
    tbl[6] = '{8'h73, 1'b1, 0, 1'b1, 1'b0, 8'h73, 1'b1, 1'b0, 1'b0, 0, int'(DEC_EN)};

    m_data = 8'h00;
    m_rdy  = 1'b0;
    m_frm  = 1'b0;
    m_ovr  = 1'b0;

    // Reset state, checked while reset is still held.
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    $display("reset: rx_data=%02h rdy=%0b frm_err=%0b ovr_err=%0b", rx_data, rdy, frm_err, ovr_err);

    // Directed frames; the model follows along so random frames start in sync.
    for (int i = 0; i < 7; i++) begin
      run_row(tbl[i], $sformatf("row%0d", i));
      v = model_predict(tbl[i]);
    end

    // Short low glitch on an idle line: nothing may change.
    RX = 1'b0;
    repeat (4) @(negedge clk);
    RX = 1'b1;
    repeat (20) @(negedge clk);
    $display("glitch: rx_data=%02h rdy=%0b frm_err=%0b", rx_data, rdy, frm_err);
    chk("glitch.rdy", 32'(rdy), 32'h1);
    chk("glitch.rx_data", 32'(rx_data), 32'h73);
    chk("glitch.frm_err", 32'(frm_err), 32'h0);

    // Stop bit stuck low for 12 more bit times, frm_err acked mid-hold:
    // a receiver that re-armed while the line was low would reframe and
    // raise frm_err again before the line recovers.
    send_frame(8'h55, 1'b0, 12, FRAME_STEPS + 3 * BD, lat, gn, sn);
    $display("stuck_low: rx_data=%02h rdy=%0b frm_err=%0b ovr_err=%0b latency=%0d",
             rx_data, rdy, frm_err, ovr_err, lat);
    chk("stuck_low.frm_err", 32'(frm_err), 32'h0);
    chk("stuck_low.rdy", 32'(rdy), 32'h0);
    chk("stuck_low.rx_data", 32'(rx_data), 32'h73);
    chk("stuck_low.no_rdy_rise", 32'(lat), 32'(-1));
    m_rdy = 1'b0;
    m_frm = 1'b0;
    m_ovr = 1'b0;

    // Random frames against the reference model.
    for (int i = 0; i < 12; i++) begin
      pick         = int'($urandom_range(0, 3));
      v.data       = (pick == 0) ? 8'h67 : (pick == 1) ? 8'h73 : 8'($urandom);
      v.stop_ok    = ($urandom_range(0, 3) != 0);
      v.extra      = v.stop_ok ? 0 : int'($urandom_range(0, 2));
      v.clr_before = 1'($urandom_range(0, 1));
      v.clr_done   = v.stop_ok && ($urandom_range(0, 2) == 0);
      v = model_predict(v);
      run_row(v, $sformatf("rand%0d", i));
    end

    // Mid-frame reset: load rdy/ovr_err first, then reset during data bit 4.
    v = '{8'h3C, 1'b1, 0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 0, 0};
    v = model_predict(v);
    run_row(v, "pre_reset");
    for (int j = 0; j < 5 * BD + BD / 2; j++) begin
      RX = level_at(8'hFF, 1'b1, 0, j);
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    chk_all_zero("midframe_reset");
    $display("midframe_reset: rx_data=%02h rdy=%0b frm_err=%0b ovr_err=%0b", rx_data, rdy, frm_err, ovr_err);
    RX = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_data = 8'h00;
    m_rdy  = 1'b0;
    m_frm  = 1'b0;
    m_ovr  = 1'b0;
    @(negedge clk);
    v = '{8'h67, 1'b1, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 0};
    v = model_predict(v);
    run_row(v, "post_reset");

    chk("go_stop_pulse_rules", 32'(pulse_err), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
